// File: rtl/hilo_sequencer_if.sv
// Handshake bundle between the main control FSM, the MULT/DIV units and the HI/LO sequencer.
// The sequencer side uses the slave modport. The controller/datapath side uses the master modport.
interface hilo_sequencer_if;
    logic Start;
    logic Op;
    logic BZero;
    logic Multiplicador;
    logic Divisor;
    logic MultControl;
    logic DivControl;
    logic CHi;
    logic CLo;
    logic MuxHILO;
    logic Busy;
    logic Done;
    logic DivZero;
    logic Timeout;

    modport master (
        output Start, Op, BZero, Multiplicador, Divisor,
        input  MultControl, DivControl, CHi, CLo, MuxHILO, Busy, Done, DivZero, Timeout
    );

    modport slave (
        input  Start, Op, BZero, Multiplicador, Divisor,
        output MultControl, DivControl, CHi, CLo, MuxHILO, Busy, Done, DivZero, Timeout
    );
endinterface

// File: rtl/hilo_sequencer.sv
// Sequences one MULT/DIV operation, then writes the result into HI/LO or raises divide-by-zero or timeout.
// Latency: the unit start pulse comes 1 cycle after Start. The HI/LO write comes 1 cycle after the unit's done flag.
// Backpressure: Start is accepted only in IDLE (Busy low). Optional watchdog: HILO_SEQUENCER_TIMEOUT_EN.
module hilo_sequencer (
    input  logic            clock,
    input  logic            reset,
    hilo_sequencer_if.slave hl
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MSTART = 3'd1,
        MWAIT  = 3'd2,
        DSTART = 3'd3,
        DWAIT  = 3'd4,
        WRITE  = 3'd5,
        EXC    = 3'd6,
        TOUT   = 3'd7
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   mux_q;
    logic   wdog_expired;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (hl.Start) begin
                    if (!hl.Op) begin
                        state_d = MSTART;
                    end else if (hl.BZero) begin
                        state_d = EXC;
                    end else begin
                        state_d = DSTART;
                    end
                end
            end
            MSTART: state_d = MWAIT;
            DSTART: state_d = DWAIT;
            // A done flag seen on the last watchdog count still completes the operation.
            MWAIT: begin
                if (hl.Multiplicador) begin
                    state_d = WRITE;
                end else if (wdog_expired) begin
                    state_d = TOUT;
                end
            end
            DWAIT: begin
                if (hl.Divisor) begin
                    state_d = WRITE;
                end else if (wdog_expired) begin
                    state_d = TOUT;
                end
            end
            WRITE:   state_d = IDLE;
            EXC:     state_d = IDLE;
            TOUT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The result source is captured with the request and held across later idle cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mux_q <= 1'b0;
        end else if (state_q == IDLE && hl.Start) begin
            mux_q <= hl.Op;
        end
    end

`ifdef HILO_SEQUENCER_TIMEOUT_EN
    logic [5:0] wdog_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wdog_q <= 6'd0;
        end else if (state_q == MSTART || state_q == DSTART) begin
            wdog_q <= 6'd0;
        end else if (state_q == MWAIT || state_q == DWAIT) begin
            wdog_q <= wdog_q + 6'd1;
        end
    end

    assign wdog_expired = (wdog_q == 6'd63);
    assign hl.Timeout   = (state_q == TOUT);
`else
    assign wdog_expired = 1'b0;
    assign hl.Timeout   = 1'b0;
`endif

    assign hl.MultControl = (state_q == MSTART);
    assign hl.DivControl  = (state_q == DSTART);
    assign hl.CHi         = (state_q == WRITE);
    assign hl.CLo         = (state_q == WRITE);
    assign hl.Done        = (state_q == WRITE) || (state_q == EXC);
    assign hl.DivZero     = (state_q == EXC);
    assign hl.Busy        = (state_q != IDLE);
    assign hl.MuxHILO     = mux_q;

endmodule

// File: doc/hilo_sequencer.md
HILO_SEQUENCER -- requirements
Module: hilo_sequencer

Interface
REQ-001 The block SHALL have port clock, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port Start, input, 1 bit: request from main control FSM to begin a MULT/DIV.
REQ-004 The block SHALL have port Op, input, 1 bit: operation select, sampled with Start; 0=MULT, 1=DIV.
REQ-005 The block SHALL have port BZero, input, 1 bit: divisor-is-zero flag, sampled with Start.
REQ-006 The block SHALL have port Multiplicador, input, 1 bit: multiplier done flag.
REQ-007 The block SHALL have port Divisor, input, 1 bit: divider done flag.
REQ-008 The block SHALL have port MultControl, output, 1 bit: one-cycle multiplier start pulse.
REQ-009 The block SHALL have port DivControl, output, 1 bit: one-cycle divider start pulse.
REQ-010 The block SHALL have port CHi, output, 1 bit: HI register write enable.
REQ-011 The block SHALL have port CLo, output, 1 bit: LO register write enable.
REQ-012 The block SHALL have port MuxHILO, output, 1 bit: HI/LO source select; 0=multiplier, 1=divider.
REQ-013 The block SHALL have port Busy, output, 1 bit: high whenever state is not IDLE.
REQ-014 The block SHALL have port Done, output, 1 bit: one-cycle completion pulse.
REQ-015 The block SHALL have port DivZero, output, 1 bit: one-cycle divide-by-zero exception pulse.
REQ-016 The block SHALL have port Timeout, output, 1 bit: one-cycle watchdog pulse; see Configuration.

Function
REQ-017 The block SHALL implement states IDLE, MSTART, MWAIT, DSTART, DWAIT, WRITE, EXC, TOUT.
REQ-018 In IDLE, Start=1 with Op=0 SHALL go to MSTART; Op=1 and BZero=0 to DSTART; Op=1 and BZero=1 to EXC.
REQ-019 Start SHALL be ignored in every state other than IDLE.
REQ-020 MSTART SHALL assert MultControl for exactly one cycle, then go to MWAIT; DSTART likewise with DivControl, then DWAIT.
REQ-021 Done flags SHALL be ignored in IDLE, MSTART, and DSTART.
REQ-022 MWAIT SHALL go to WRITE on Multiplicador=1; DWAIT SHALL go to WRITE on Divisor=1; the other unit's flag SHALL be ignored.
REQ-023 WRITE SHALL assert CHi, CLo, and Done for exactly one cycle, then go to IDLE.
REQ-024 MuxHILO SHALL be registered on acceptance of Start as Op and held until the next accepted Start.
REQ-025 EXC SHALL assert DivZero and Done for one cycle, with no CHi/CLo and no DivControl, then go to IDLE.
REQ-026 Latency: with Start in cycle 0 and the done flag high in cycle k, CHi/CLo SHALL assert in cycle k+1; minimum k=2.
REQ-027 All outputs SHALL be decoded from registered state, with no combinational path from inputs to outputs.

Reset
REQ-028 Reset low SHALL immediately force IDLE, clear the watchdog counter, and drive every output to 0, including MuxHILO.
REQ-029 Reset asserted mid-operation SHALL abort without any CHi/CLo/Done pulse; a pending unit result SHALL be discarded.

Configuration
REQ-030 Macro HILO_SEQUENCER_TIMEOUT_EN SHALL control a 6-bit watchdog counter.
REQ-031 With the macro defined, the counter SHALL clear on entering MWAIT/DWAIT and increment each wait cycle.
REQ-032 With the macro defined, if the counter reaches 63 with no done flag, the block SHALL go to TOUT.
REQ-033 TOUT SHALL pulse Timeout for one cycle, with no CHi/CLo/Done, then go to IDLE.
REQ-034 If the done flag is high in the same cycle the counter reaches 63, done SHALL win.
REQ-035 Without the macro, the wait states SHALL wait indefinitely, TOUT SHALL be unreachable, and Timeout SHALL be tied 0.

Verification
REQ-036 MULT path: Start=1, Op=0 in cycle 0; Multiplicador=1 in cycle 5 -> MultControl=1 in cycle 1 only; CHi=CLo=Done=1 in cycle 6; MuxHILO=0; Busy=1 in cycles 1-6.
REQ-037 DIV by zero: Start=1, Op=1, BZero=1 -> DivZero=Done=1 in cycle 1; DivControl, CHi, and CLo never asserted.
REQ-038 Ignored inputs: Start re-pulsed in DWAIT and Multiplicador=1 in DWAIT -> no state change; Divisor=1 later -> single WRITE with MuxHILO=1.
REQ-039 Reset abort: reset low in MWAIT, Multiplicador=1 after release -> all outputs 0 and no CHi/CLo ever asserted.
REQ-040 Timeout (macro defined): DIV started, Divisor held 0 -> Timeout=1 exactly 64 cycles after DWAIT entry, then IDLE; same case with Divisor=1 on the 63rd count -> WRITE and no Timeout.
